// File: rtl/lane_stream_buffer_if.sv
// Handshake bundle for lane_stream_buffer: a one-word write stream in, a
// LANES-word beat stream out, plus fill-level status.
interface lane_stream_buffer_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int LANES  = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    flush;
  logic                    wr_valid;
  logic [DATA_W-1:0]       wr_data;
  logic                    wr_ready;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [LANES*DATA_W-1:0] rd_data;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    empty;
  logic                    overflow;

  modport master (
    output flush, wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, count, full, empty, overflow
  );

  modport slave (
    input  flush, wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, count, full, empty, overflow
  );
endinterface

// File: rtl/lane_stream_buffer.sv
// Circular word buffer that packs LANES stored words into one output beat,
// oldest word in the most significant lane, behind a single output register.
module lane_stream_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 128,
  parameter int LANES  = 2
) (
  input logic               clk,
  input logic               rst,
  lane_stream_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = LANES * DATA_W;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] LANES_C = CW'(LANES);
  localparam logic [AW-1:0] STEP_C  = AW'(LANES);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          rd_valid_reg, rd_valid_next;
  logic [BW-1:0] rd_data_reg, rd_data_next;
  logic          overflow_reg, overflow_next;

  logic          full;
  logic          wr_fire;
  logic          load;
  logic [BW-1:0] beat_word;

  assign full    = (count_reg == DEPTH_C);
  assign wr_fire = bus.wr_valid && !full && !bus.flush;
  assign load    = (!rd_valid_reg || bus.rd_ready) && (count_reg >= LANES_C) && !bus.flush;

  // Lane gi reads the word gi places after the oldest; lane 0 lands in the top slice.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [AW-1:0] lane_addr;
      assign lane_addr = rd_ptr_reg + AW'(gi);
      assign beat_word[(LANES-1-gi)*DATA_W +: DATA_W] = mem[lane_addr];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg] <= bus.wr_data;
    end
  end

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    rd_valid_next = rd_valid_reg;
    rd_data_next  = rd_data_reg;
    overflow_next = overflow_reg;

    if (bus.flush) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
      rd_valid_next = 1'b0;
      rd_data_next  = '0;
      overflow_next = 1'b0;
    end else begin
      if (wr_fire) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end

      if (load) begin
        rd_ptr_next   = rd_ptr_reg + STEP_C;
        rd_valid_next = 1'b1;
        rd_data_next  = beat_word;
      end else if (rd_valid_reg && bus.rd_ready) begin
        rd_valid_next = 1'b0;
        rd_data_next  = '0;
      end

      count_next = count_reg + (wr_fire ? CW'(1) : '0) - (load ? LANES_C : '0);

      // A refused write is remembered until flush or reset; the word itself is dropped.
      if (bus.wr_valid && full) begin
        overflow_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      overflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      rd_valid_reg <= rd_valid_next;
      rd_data_reg  <= rd_data_next;
      overflow_reg <= overflow_next;
    end
  end

  assign bus.wr_ready = !full;
  assign bus.rd_valid = rd_valid_reg;
  assign bus.rd_data  = rd_data_reg;
  assign bus.count    = count_reg;
  assign bus.full     = full;
  assign bus.empty    = (count_reg == '0);
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_lane_stream_buffer.sv
// Randomized and directed checks of lane_stream_buffer against a queue-based
// model of the stored words and the output beat.
module tb_lane_stream_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 128;
  localparam int LANES  = 2;
  localparam int BW     = LANES * DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lane_stream_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) bus ();

  lane_stream_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference state: stored words in arrival order plus the output register.
  logic [DATA_W-1:0] m_q [$];
  logic              m_valid;
  logic [BW-1:0]     m_data;
  logic              m_ovf;

  logic [BW-1:0] consumed [$];
  bit            record_beats = 1'b0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 1'b0;
  endtask

  task automatic check_all();
    check("count",    128'(bus.count),    128'(m_q.size()));
    check("rd_valid", 128'(bus.rd_valid), 128'(m_valid));
    check("rd_data",  128'(bus.rd_data),  128'(m_data));
    check("full",     128'(bus.full),     128'(m_q.size() == DEPTH));
    check("empty",    128'(bus.empty),    128'(m_q.size() == 0));
    check("wr_ready", 128'(bus.wr_ready), 128'(m_q.size() != DEPTH));
    check("overflow", 128'(bus.overflow), 128'(m_ovf));
  endtask

  // Advance one clock: apply the buffer rules to the model, then compare.
  task automatic tick();
    bit            is_full;
    bit            do_wr;
    bit            do_load;
    logic [BW-1:0] beat;
    if (record_beats && bus.rd_valid && bus.rd_ready) begin
      consumed.push_back(bus.rd_data);
    end
    if (bus.flush) begin
      model_reset();
    end else begin
      is_full = (m_q.size() == DEPTH);
      do_wr   = bus.wr_valid && !is_full;
      do_load = (!m_valid || bus.rd_ready) && (m_q.size() >= LANES);
      if (bus.wr_valid && is_full) m_ovf = 1'b1;
      if (do_load) begin
        beat = '0;
        for (int i = 0; i < LANES; i++) beat = (beat << DATA_W) | BW'(m_q.pop_front());
        m_valid = 1'b1;
        m_data  = beat;
      end else if (m_valid && bus.rd_ready) begin
        m_valid = 1'b0;
        m_data  = '0;
      end
      if (do_wr) m_q.push_back(bus.wr_data);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic write_word(input logic [DATA_W-1:0] w);
    bus.wr_valid = 1'b1;
    bus.wr_data  = w;
    tick();
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    logic [BW-1:0] exp_beat;
    int            wr_pct [4] = '{90, 50, 95, 30};
    int            rd_pct [4] = '{90, 50, 20, 95};

    bus.flush    = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.rd_ready = 1'b0;
    model_reset();

    // Power-on reset
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all();
    #3 rst = 1'b0;
    check("post_rst_full",     128'(bus.full),     128'(0));
    check("post_rst_empty",    128'(bus.empty),    128'(1));
    check("post_rst_wr_ready", 128'(bus.wr_ready), 128'(1));

    // First beat: two writes, beat visible one edge after the second
    bus.rd_ready = 1'b1;
    write_word(32'h11);
    write_word(32'h22);
    tick();
    check("first_valid", 128'(bus.rd_valid), 128'(1));
    check("first_data",  128'(bus.rd_data),  128'(64'h00000011_00000022));
    check("first_count", 128'(bus.count),    128'(0));
    $display("[TB] first beat data=%h", bus.rd_data);
    tick();

    // Fill with no consumer, then one refused write
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 130; i++) write_word(DATA_W'(32'h1000 + i));
    check("fill_full",     128'(bus.full),     128'(1));
    check("fill_wr_ready", 128'(bus.wr_ready), 128'(0));
    check("fill_count",    128'(bus.count),    128'(128));
    write_word(32'hBAD0_0000);
    check("ovf_flag",  128'(bus.overflow), 128'(1));
    check("ovf_count", 128'(bus.count),    128'(128));
    $display("[TB] fill done count=%0d overflow=%0b", bus.count, bus.overflow);

    // Asynchronous reset mid-cycle with a live beat and sticky overflow
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("arst_valid", 128'(bus.rd_valid), 128'(0));
    check("arst_data",  128'(bus.rd_data),  128'(0));
    check("arst_count", 128'(bus.count),    128'(0));
    check("arst_empty", 128'(bus.empty),    128'(1));
    check("arst_ovf",   128'(bus.overflow), 128'(0));
    #2 rst = 1'b0;
    $display("[TB] async reset applied");

    // Wrap-around stream of 300 ascending words
    bus.rd_ready = 1'b1;
    consumed.delete();
    record_beats = 1'b1;
    for (int i = 0; i < 300; i++) write_word(DATA_W'(i));
    repeat (6) tick();
    record_beats = 1'b0;
    check("wrap_beats", 128'(consumed.size()), 128'(150));
    for (int k = 0; k < 150 && k < consumed.size(); k++) begin
      exp_beat = (BW'(2 * k) << DATA_W) | BW'(2 * k + 1);
      check("wrap_data", 128'(consumed[k]), 128'(exp_beat));
      $display("[TB] beat %0d data=%h", k, consumed[k]);
    end

    // Backpressure: beat must hold while the memory keeps filling
    bus.rd_ready = 1'b0;
    for (int i = 0; i < 4; i++) write_word(DATA_W'(32'hA0 + i));
    check("bp_data0",  128'(bus.rd_data), 128'(64'h000000A0_000000A1));
    check("bp_count0", 128'(bus.count),   128'(2));
    for (int i = 0; i < 5; i++) write_word(DATA_W'(32'hB0 + i));
    check("bp_data1",  128'(bus.rd_data),  128'(64'h000000A0_000000A1));
    check("bp_valid1", 128'(bus.rd_valid), 128'(1));
    check("bp_count1", 128'(bus.count),    128'(7));
    $display("[TB] backpressure count=%0d data=%h", bus.count, bus.rd_data);

    // Flush racing a write
    for (int i = 0; i < 3; i++) write_word(DATA_W'(32'hC0 + i));
    check("pre_flush_count", 128'(bus.count),    128'(10));
    check("pre_flush_valid", 128'(bus.rd_valid), 128'(1));
    bus.flush = 1'b1;
    write_word(32'hDEAD_BEEF);
    bus.flush = 1'b0;
    check("flush_count", 128'(bus.count),    128'(0));
    check("flush_valid", 128'(bus.rd_valid), 128'(0));
    check("flush_data",  128'(bus.rd_data),  128'(0));
    bus.rd_ready = 1'b1;
    write_word(32'h1);
    write_word(32'h2);
    tick();
    check("post_flush_data", 128'(bus.rd_data), 128'(64'h00000001_00000002));
    $display("[TB] post-flush beat data=%h", bus.rd_data);
    tick();

    // Randomized traffic with occasional flushes
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < 500; c++) begin
        bus.wr_valid = ($urandom_range(0, 99) < wr_pct[s]);
        bus.wr_data  = DATA_W'($urandom);
        bus.rd_ready = ($urandom_range(0, 99) < rd_pct[s]);
        bus.flush    = ($urandom_range(0, 199) == 0);
        tick();
      end
      bus.flush    = 1'b0;
      bus.wr_valid = 1'b0;
      $display("[TB] random segment %0d count=%0d overflow=%0b", s, bus.count, bus.overflow);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/lane_stream_buffer.md
LANE_STREAM_BUFFER -- requirements
Module: lane_stream_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the width of one stored word.
REQ-002 SHALL have parameter DEPTH, default 128, the word capacity of storage memory; power of two, >= 2*LANES.
REQ-003 SHALL have parameter LANES, default 2, the words concatenated per output beat; >= 1.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port flush, input, 1, synchronous clear of all stored data.
REQ-007 SHALL have port wr_valid, input, 1, write request.
REQ-008 SHALL have port wr_data, input, DATA_W, write word.
REQ-009 SHALL have port wr_ready, output, 1, write accepted this cycle if wr_valid.
REQ-010 SHALL have port rd_valid, output, 1, output beat present.
REQ-011 SHALL have port rd_ready, input, 1, consumer accepts beat.
REQ-012 SHALL have port rd_data, output, LANES*DATA_W, output beat.
REQ-013 SHALL have port count, output, $clog2(DEPTH)+1, words held in memory (excluding the output register).
REQ-014 SHALL have ports full/empty, output, 1 each, where full = (count==DEPTH) and empty = (count==0).
REQ-015 SHALL have port overflow, output, 1, sticky flag: write attempted while full.

Function
REQ-016 SHALL drive wr_ready = !full combinationally; write accepted at an edge iff wr_valid && wr_ready && !flush.
REQ-017 SHALL store an accepted word at wr_ptr and advance wr_ptr modulo DEPTH (wrap DEPTH-1 -> 0).
REQ-018 SHALL use a single registered output stage, loaded at an edge iff (!rd_valid || rd_ready) && count >= LANES && !flush.
REQ-019 SHALL on load place the oldest word in the most significant lane: rd_data = {mem[rd_ptr], mem[rd_ptr+1], ..., mem[rd_ptr+LANES-1]} (indices modulo DEPTH), with rd_ptr += LANES modulo DEPTH.
REQ-020 SHALL keep rd_valid=1 and rd_data stable while rd_valid && !rd_ready.
REQ-021 SHALL on a beat consumed (rd_valid && rd_ready) with no reload, clear rd_valid to 0 and rd_data to 0 at that edge.
REQ-022 SHALL hold rd_data = 0 whenever rd_valid = 0.
REQ-023 SHALL update count at each edge by +1 (write) and -LANES (load); simultaneous write and load yields count + 1 - LANES.
REQ-024 SHALL never emit a partial beat; fewer than LANES words remain stored until enough arrive.
REQ-025 SHALL impose latency as follows: write accepted at edge E that makes count >= LANES -> load at edge E+1 -> rd_valid=1 after E+1.
REQ-026 SHALL set overflow at an edge where wr_valid && !wr_ready; the word SHALL be discarded and storage untouched.
REQ-027 SHALL on flush=1 at an edge set wr_ptr, rd_ptr, count, rd_valid, rd_data and overflow to 0, ignoring any simultaneous write or load.
REQ-028 SHALL hold total capacity at DEPTH + LANES words (memory plus output register).

Reset
REQ-029 SHALL on rst=1 immediately (asynchronously) force wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, rd_data=0, overflow=0; memory contents need not be cleared.
REQ-030 SHALL after rst deassertion have full=0, empty=1, wr_ready=1; rst asserted mid-stream SHALL discard all stored and in-flight data.

Verification
REQ-031 SHALL verify reset: pulse rst mid-cycle -> outputs at once rd_valid=0, rd_data=0, count=0, empty=1, overflow=0.
REQ-032 SHALL verify first beat: write 0x11, 0x22 on consecutive cycles with rd_ready=1 -> one edge after the second write, rd_valid=1, rd_data=0x00000011_00000022, count=0.
REQ-033 SHALL verify fill/overflow: rd_ready=0, write 130 words -> full=1, wr_ready=0, count=128; 131st write -> overflow=1, count stays 128.
REQ-034 SHALL verify wrap-around: write 0..299 ascending, rd_ready=1 -> 150 beats {k,k+1} for k=0,2,..,298 in order, no loss or duplication.
REQ-035 SHALL verify backpressure: rd_valid=1, rd_ready=0 for 5 cycles while writing -> rd_data unchanged, count +5.
REQ-036 SHALL verify flush with a simultaneous write: count=10, rd_valid=1 -> next edge count=0, rd_valid=0, rd_data=0, written word discarded.
